// File: rtl/de_stub_seq.sv
// de_stub_seq: table-driven decode-stage stub feeding micro-op bundles into AG.
//
// A programmable table of up to DEPTH packed bundles is replayed in order, one
// entry per AG accept. Replay is one-shot or looping and the accepted bundles
// are counted (saturating).
//
// Optional feature: define DE_STUB_BRANCH_EN to make entries with a non-zero
// jmp field redirect the replay pointer to disp[AW-1:0].
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, loop, prog_len    replay control (honoured in IDLE/DONE only)
//   prog_we/addr/data        table write port (honoured in IDLE/DONE only)
//   de_v, reg_dep, mem_dep,
//   mr_stall, mw_stall       pipeline handshake inputs
//   de_* , ro/rm_needed      decoded bundle fields of the current entry
//   ld_ag, ag_vin            AG latch enable and valid
//   busy, done, issued       status and accepted-bundle count
module de_stub_seq #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  loop,
  input  logic [AW:0]           prog_len,
  input  logic                  prog_we,
  input  logic [AW-1:0]         prog_addr,
  input  logic [5*DATA_W+49:0]  prog_data,
  input  logic                  de_v,
  input  logic                  reg_dep,
  input  logic                  mem_dep,
  input  logic                  mr_stall,
  input  logic                  mw_stall,
  output logic                  de_re,
  output logic                  de_we,
  output logic                  de_rmsel,
  output logic [1:0]            de_alusel,
  output logic [DATA_W-1:0]     de_dval,
  output logic [DATA_W-1:0]     de_sval,
  output logic [DATA_W-1:0]     de_disp,
  output logic [DATA_W-1:0]     de_flags,
  output logic [DATA_W-1:0]     de_flag_ld,
  output logic [15:0]           de_sreg,
  output logic [15:0]           de_ptr,
  output logic [7:0]            de_modrm,
  output logic [2:0]            de_jmp,
  output logic                  ro_needed,
  output logic                  rm_needed,
  output logic                  ld_ag,
  output logic                  ag_vin,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      issued
);

  localparam int unsigned PW = 5 * DATA_W + 50;
  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             loop_q, loop_d;
  logic [AW:0]      len_q, len_d;
  logic [PW-1:0]    table_q [DEPTH];

  logic [PW-1:0]    entry;
  logic [AW:0]      len_clip;
  logic             accept;
  logic             last;

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign issued = issued_q;

  assign ld_ag  = ~(mem_dep | mr_stall | mw_stall);
  assign ag_vin = busy & de_v & ~reg_dep;
  assign accept = ld_ag & ag_vin;

  // The table pointer only moves on accept, so the bundle holds across stalls.
  assign entry = busy ? table_q[ptr_q] : '0;
  assign {de_re, de_we, de_rmsel, de_alusel, de_dval, de_sval, de_disp, de_flags, de_flag_ld,
          de_sreg, de_ptr, de_modrm, de_jmp, ro_needed, rm_needed} = entry;

  assign len_clip = (prog_len > DepthW) ? DepthW : prog_len;
  assign last     = ({1'b0, ptr_q} == (len_q - (AW + 1)'(1)));

`ifdef DE_STUB_BRANCH_EN
  logic [AW-1:0] br_tgt;
  logic          br_take;
  assign br_tgt  = de_disp[AW-1:0];
  assign br_take = (de_jmp != 3'b000);
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    issued_d = issued_q;
    loop_d   = loop_q;
    len_d    = len_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          ptr_d    = '0;
          issued_d = '0;
          loop_d   = loop;
          len_d    = len_clip;
          state_d  = (len_clip == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          if (issued_q != '1) begin
            issued_d = issued_q + CNT_W'(1);
          end
`ifdef DE_STUB_BRANCH_EN
          // A taken branch overrides the last-entry wrap/stop rule.
          if (br_take) begin
            if ({1'b0, br_tgt} >= len_q) begin
              ptr_d   = '0;
              state_d = StDone;
            end else begin
              ptr_d = br_tgt;
            end
          end else
`endif
          if (!last) begin
            ptr_d = ptr_q + AW'(1);
          end else if (loop_q) begin
            ptr_d = '0;
          end else begin
            ptr_d   = '0;
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      issued_q <= '0;
      loop_q   <= 1'b0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      issued_q <= issued_d;
      loop_q   <= loop_d;
      len_q    <= len_d;
    end
  end

  // Writes land at the same edge as a start, so a new run sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else if (prog_we && !busy) begin
      table_q[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_de_stub_seq.sv
module tb_de_stub_seq;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int CW    = 16;
  localparam int PW    = 5 * DW + 50;
  localparam int ALU_LSB  = 45 + 5 * DW;
  localparam int DISP_LSB = 45 + 2 * DW;
  localparam int JMP_LSB  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, loop, prog_we;
  logic [AW:0]   prog_len;
  logic [AW-1:0] prog_addr;
  logic [PW-1:0] prog_data;
  logic          de_v, reg_dep, mem_dep, mr_stall, mw_stall;
  logic          de_re, de_we, de_rmsel, ro_needed, rm_needed;
  logic [1:0]    de_alusel;
  logic [DW-1:0] de_dval, de_sval, de_disp, de_flags, de_flag_ld;
  logic [15:0]   de_sreg, de_ptr;
  logic [7:0]    de_modrm;
  logic [2:0]    de_jmp;
  logic          ld_ag, ag_vin, busy, done;
  logic [CW-1:0] issued;

  always #5 clk = ~clk;

  de_stub_seq #(.DEPTH(DEPTH), .AW(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .prog_len(prog_len),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .de_v(de_v), .reg_dep(reg_dep), .mem_dep(mem_dep), .mr_stall(mr_stall),
    .mw_stall(mw_stall), .de_re(de_re), .de_we(de_we), .de_rmsel(de_rmsel),
    .de_alusel(de_alusel), .de_dval(de_dval), .de_sval(de_sval), .de_disp(de_disp),
    .de_flags(de_flags), .de_flag_ld(de_flag_ld), .de_sreg(de_sreg), .de_ptr(de_ptr),
    .de_modrm(de_modrm), .de_jmp(de_jmp), .ro_needed(ro_needed), .rm_needed(rm_needed),
    .ld_ag(ld_ag), .ag_vin(ag_vin), .busy(busy), .done(done), .issued(issued)
  );

  wire [PW-1:0] out_bundle = {de_re, de_we, de_rmsel, de_alusel, de_dval, de_sval, de_disp,
                              de_flags, de_flag_ld, de_sreg, de_ptr, de_modrm, de_jmp,
                              ro_needed, rm_needed};

  logic [PW-1:0] model_tab [DEPTH];
  logic [PW-1:0] exp_q [$];
  int            total = 0;
  int            bad = 0;
  bit            run_on = 1'b0;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_bundle();
    logic [7*32-1:0] w;
    for (int i = 0; i < 7; i++) w[i*32 +: 32] = $urandom;
    return w[PW-1:0];
  endfunction

  // Monitor: handshake every cycle, bundle contents on every accept.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ld_ag", PW'(ld_ag), PW'(!(mem_dep | mr_stall | mw_stall)));
      chk("ag_vin", PW'(ag_vin), PW'(run_on & de_v & !reg_dep));
      if (ag_vin && ld_ag) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_accept: got %h expected none", out_bundle);
        end else begin
          chk("bundle", out_bundle, exp_q.pop_front());
        end
      end
    end
  end

  // Reference: walk the table by the replay rules, up to limit issues.
  task automatic plan(input int len_in, input bit lp, input int limit,
                      output bit term, output int n);
    int len, idx;
    logic [PW-1:0] e;
    len  = (len_in > DEPTH) ? DEPTH : len_in;
    n    = 0;
    term = 1'b1;
    if (len == 0) return;
    term = 1'b0;
    idx  = 0;
    while (n < limit) begin
      e = model_tab[idx];
      exp_q.push_back(e);
      n++;
`ifdef DE_STUB_BRANCH_EN
      if (e[JMP_LSB +: 3] != 3'b000) begin
        if (int'(e[DISP_LSB +: AW]) >= len) begin
          term = 1'b1;
          break;
        end
        idx = int'(e[DISP_LSB +: AW]);
        continue;
      end
`endif
      if (idx == len - 1) begin
        if (lp) idx = 0;
        else begin
          term = 1'b1;
          break;
        end
      end else idx++;
    end
  endtask

  task automatic clear_inputs();
    start = 0; loop = 0; prog_we = 0; prog_len = '0; prog_addr = '0; prog_data = '0;
    de_v = 0; reg_dep = 0; mem_dep = 0; mr_stall = 0; mw_stall = 0;
  endtask

  task automatic prog_write(input int addr, input logic [PW-1:0] data);
    @(posedge clk); #1;
    prog_we = 1; prog_addr = AW'(addr); prog_data = data;
    model_tab[addr] = data;
    @(posedge clk); #1;
    prog_we = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    de_v = 1;
    rst  = 1;
    #1;
    chk("rst_busy", PW'(busy), '0);
    chk("rst_done", PW'(done), '0);
    chk("rst_issued", PW'(issued), '0);
    chk("rst_ag_vin", PW'(ag_vin), '0);
    chk("rst_bundle", out_bundle, '0);
    for (int i = 0; i < DEPTH; i++) model_tab[i] = '0;
    exp_q.delete();
    run_on = 0;
    @(posedge clk); #1;
    rst = 0;
    clear_inputs();
  endtask

  // Returns term=0 when the run was capped while still replaying.
  task automatic do_run(input int len_in, input bit lp, input int limit, input bit wr_start,
                        output bit term);
    int n, cyc, a;
    @(posedge clk); #1;
    clear_inputs();
    if (wr_start) begin
      a = int'($urandom_range(DEPTH - 1));
      prog_we = 1; prog_addr = AW'(a); prog_data = rand_bundle();
      model_tab[a] = prog_data;
    end
    start = 1; prog_len = (AW + 1)'(len_in); loop = lp;
    plan(len_in, lp, limit, term, n);
    @(posedge clk); #1;
    clear_inputs();
    if (n == 0) begin
      chk("len0_done", PW'(done), PW'(1));
      chk("len0_busy", PW'(busy), '0);
      return;
    end
    run_on = 1;
    cyc = 0;
    forever begin
      de_v     = ($urandom % 4) != 0;
      reg_dep  = ($urandom % 5) == 0;
      mem_dep  = ($urandom % 7) == 0;
      mr_stall = ($urandom % 7) == 0;
      mw_stall = ($urandom % 7) == 0;
      // Junk control traffic that must be ignored while running.
      start    = ($urandom % 8) == 0;
      prog_len = (AW + 1)'($urandom_range(DEPTH));
      prog_we  = ($urandom % 6) == 0;
      prog_addr = AW'($urandom);
      prog_data = rand_bundle();
      @(posedge clk); #1;
      cyc++;
      if (exp_q.size() == 0) break;
      if (cyc > 3000) begin
        total++;
        bad++;
        $display("FAIL run_timeout: got %0d left expected 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    clear_inputs();
    run_on = 0;
    chk("issued", PW'(issued), PW'(n));
    chk("done", PW'(done), PW'(term));
    chk("busy", PW'(busy), PW'(!term));
    if (term) chk("idle_bundle", out_bundle, '0);
  endtask

  initial begin
    bit term;
    logic [PW-1:0] b;
    clear_inputs();
    for (int i = 0; i < DEPTH; i++) model_tab[i] = '0;
    rst = 1;
    #12;
    chk("init_busy", PW'(busy), '0);
    chk("init_done", PW'(done), '0);
    chk("init_issued", PW'(issued), '0);
    chk("init_bundle", out_bundle, '0);
    @(posedge clk); #1;
    rst = 0;

    // Three entries with alusel 3,1,2, one-shot.
    for (int i = 0; i < 3; i++) begin
      b = rand_bundle();
      b[ALU_LSB +: 2] = (i == 0) ? 2'd3 : (i == 1) ? 2'd1 : 2'd2;
`ifdef DE_STUB_BRANCH_EN
      b[JMP_LSB +: 3] = 3'b000;
`endif
      prog_write(i, b);
    end
    do_run(3, 0, 100, 0, term);

    // Loop of two, capped at five issues, then reset mid-run.
    do_run(2, 1, 5, 0, term);
    if (!term) do_reset();
    // Cleared table and clipped length: DEPTH all-zero bundles.
    do_run(DEPTH + 1, 0, 100, 0, term);
    do_run(0, 0, 100, 0, term);

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 4; k++) prog_write(int'($urandom_range(DEPTH - 1)), rand_bundle());
      do_run(int'($urandom_range(DEPTH + 1)), bit'($urandom % 2), 5 + int'($urandom % 30),
             bit'($urandom % 2), term);
      if (!term) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/de_stub_seq.md
Name: de_stub_seq

Overview:
- Parametrised, table-driven decode-stage stub that drives decoded micro-op bundles into the AG stage while the real decoder is under construction.
- Replays a programmable table of up to DEPTH bundles. The table pointer advances only when AG accepts, under the pipeline's stall and dependency handshake.
- Supports one-shot and loop replay, and counts issued bundles. Sits between fetch valid (de_v) and the AG pipeline latch.

Parameters:
- DEPTH, 16, number of table entries (power of two, ≥2).
- AW, 4, table address width; must equal log2(DEPTH).
- DATA_W, 32, width of dval, sval, disp, flags and flag_ld fields.
- CNT_W, 16, width of the issued-bundle counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins replay from entry 0 (honoured in IDLE/DONE only)
- loop  in  1  sampled at start; 1 = wrap to entry 0 after last entry
- prog_len  in  AW+1  number of valid entries, sampled at start; values >DEPTH clip to DEPTH
- prog_we  in  1  table write strobe (honoured in IDLE/DONE only)
- prog_addr  in  AW  table write address
- prog_data  in  5*DATA_W+50  packed bundle. MSB→LSB: re, we, rmsel, alusel[1:0], dval, sval, disp, flags, flag_ld, sreg[15:0], ptr[15:0], modrm[7:0], jmp[2:0], ro_needed, rm_needed
- de_v, reg_dep, mem_dep, mr_stall, mw_stall  in  1 each  handshake inputs
- de_re, de_we, de_rmsel  out  1  bundle fields
- de_alusel  out  2  bundle field
- de_dval, de_sval, de_disp, de_flags, de_flag_ld  out  DATA_W  bundle fields
- de_sreg, de_ptr  out  16  bundle fields
- de_modrm  out  8  bundle field
- de_jmp  out  3  bundle field
- ro_needed, rm_needed  out  1  bundle fields
- ld_ag  out  1  AG latch enable
- ag_vin  out  1  valid into AG
- busy  out  1  state==RUN
- done  out  1  state==DONE
- issued  out  CNT_W  accepted-bundle count

Behaviour:
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Reset (async):
  - state=IDLE, ptr=0, issued=0, loop_q=0, len_q=0.
  - All table entries cleared to 0.
  - All outputs 0.
- Handshake (combinational):
  - ld_ag = !(mem_dep | mr_stall | mw_stall).
  - ag_vin = busy & de_v & !reg_dep.
  - accept = ld_ag & ag_vin.
- Bundle outputs:
  - Combinational decode of table[ptr] while busy; forced to all-zero otherwise.
  - Held stable across stalls; no bundle is skipped or duplicated.
- IDLE/DONE + start:
  - ptr←0, issued←0, loop_q←loop, len_q←min(prog_len, DEPTH).
  - If len_q==0, go to DONE; else go to RUN.
  - Applies from DONE too (restart).
- RUN + accept:
  - issued←issued+1, saturating at all-ones.
  - If ptr != len_q-1: ptr←ptr+1.
  - Else if loop_q: ptr←0, stay RUN.
  - Else: go to DONE with ptr←0.
- RUN, no accept: all state holds.
- prog_we:
  - Writes table[prog_addr] at the clock edge in IDLE/DONE.
  - Ignored in RUN. start is also ignored in RUN.
  - A same-cycle prog_we and start both take effect: the write completes and the new run sees the written data.
- Latency: first bundle is visible the cycle after start. Maximum throughput is one bundle per cycle.
- rst asserted mid-RUN: immediate return to IDLE with the table cleared.

Optional Feature:
- Macro DE_STUB_BRANCH_EN.
- Defined:
  - On accept of an entry with de_jmp != 3'b000, next ptr = de_disp[AW-1:0] instead of the sequential successor.
  - If that target ≥ len_q, go to DONE.
  - Branch takes precedence over the last-entry wrap/stop rule.
- Undefined: de_jmp is a pass-through field only; sequencing is purely sequential.

Test Plan:
- Program 3 entries (alusel 3,1,2), prog_len=3, loop=0, start, de_v=1, no stalls → ag_vin high 3 cycles, de_alusel 3,1,2, issued=3, done=1 on 4th cycle.
- Same program with mr_stall=1 for 2 cycles during entry 1 → ld_ag=0, de_alusel holds 1 for 3 cycles, sequence unchanged, issued=3.
- reg_dep=1 for 1 cycle during entry 0 → ag_vin=0 that cycle, ptr holds, entry 0 issued once.
- loop=1, prog_len=2, 5 accepts → entries 0,1,0,1,0, busy stays 1, issued=5; prog_we during RUN leaves table[0] unchanged.
- prog_len=0 start → done the next cycle, ag_vin never asserted. prog_len=DEPTH+1 → clips to DEPTH.
- Async rst mid-RUN → outputs 0 immediately, state IDLE, table cleared. With DE_STUB_BRANCH_EN, entry 1 jmp=1, disp=0, len=3 → issue order 0,1,0,1,…
